load_store_unit: RTL
====================

# load_store_unit

Memory-stage load/store unit sitting directly downstream of the ALU. It takes `ALUResult` as the effective byte address, performs one data-memory transaction per load/store over a req/ready handshake, and returns sign- or zero-extended load data to writeback. While a transaction is outstanding it stalls the pipeline. It flags misaligned or illegal-size accesses instead of issuing them.

## Interface
- `DATA_WIDTH`, 32: data and address width; only 32 is supported.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ALUResult` in 32: effective byte address.
- `WriteData` in 32: store source (rs2).
- `MemRead` / `MemWrite` in 1: load or store request, held stable by the pipeline while `Stall`=1.
- `Funct3` in 3: size. 000 B, 001 H, 010 W, 100 BU, 101 HU. Other codes are illegal.
- `Stall` out 1: hold the upstream pipeline.
- `ReadData` out 32: extended load result.
- `LoadValid` out 1: one-cycle pulse; `ReadData` is valid.
- `MisalignedErr` out 1: one-cycle pulse; access was rejected.
- `MemReq` out 1, `MemWe` out 1, `MemAddr` out 32, `MemWData` out 32, `MemBe` out 4: bus request.
- `MemReady` in 1, `MemRData` in 32: bus response.

## Operation
- FSM states are IDLE, ACCESS and DONE.
- **IDLE**
  - If `MemRead|MemWrite`=1, the unit decodes the request. If both are 1, `MemWrite` wins.
  - Legal and aligned: latch the word address `{ALUResult[31:2],2'b00}`, `ALUResult[1:0]`, `Funct3`, the direction, `MemBe` and `MemWData`, then go to ACCESS.
  - Misaligned (H/HU with addr[0]=1, W with addr[1:0]≠0) or illegal `Funct3`: set the error flag, go to DONE, no bus access.
- **ACCESS**
  - `MemReq`=1. `MemAddr`, `MemWe`, `MemBe` and `MemWData` are held constant until `MemReady` is sampled 1.
  - On that edge: for a load, capture the extended `MemRData` into `ReadData`; go to DONE.
- **DONE**
  - Deassert `Stall`. Pulse `LoadValid` (load) or `MisalignedErr` (error) for this cycle only.
  - Go to IDLE unconditionally. Request inputs seen in DONE belong to the finishing instruction and are ignored.
- **Byte enables and store data**
  - B: `MemBe`=0001<<a[1:0], byte replicated in all 4 lanes.
  - H: `MemBe`=0011<<a[1:0], halfword replicated in both halves.
  - W: `MemBe`=1111.
  - Loads drive the same `MemBe`.
- **Load extraction**
  - Lane = `MemRData`>>(8·a[1:0]).
  - B/H are sign-extended from bit 7/15; BU/HU are zero-extended; W passes through.
- `MemReady` is ignored outside ACCESS.
- **Reset values:** state IDLE, and all outputs 0: `Stall`, `LoadValid`, `MisalignedErr`, `MemReq`, `MemWe`, `MemBe`, `MemAddr`, `MemWData`, `ReadData`.

## Timing
- `Stall` is combinational: 1 in IDLE when a request is present, 1 throughout ACCESS, 0 in DONE.
- **Memory access, zero wait states**
  - Cycle 0: IDLE, request seen, `Stall`=1.
  - Cycle 1: ACCESS, `MemReady`=1.
  - Cycle 2: DONE, `LoadValid`.
- Minimum latency is 3 cycles. Each cycle of `MemReady`=0 adds one cycle.
- **Error access:** cycle 0 IDLE (`Stall`=1), cycle 1 DONE (`MisalignedErr`=1). `MemReq` never rises.
- `ReadData` holds its value until the next load completes.
- **Reset mid-ACCESS:** all outputs clear immediately (asynchronous). The transaction is abandoned and no `LoadValid` is issued.
- Back-to-back accesses: the next request is accepted in the IDLE cycle after DONE.

## Test plan
- SW at addr 0x100, `WriteData`=0xDEADBEEF, `MemReady` asserted in cycle 1 -> `MemAddr`=0x100, `MemBe`=1111, `MemWe`=1, `MemWData`=0xDEADBEEF; `Stall` high in cycles 0–1, low in cycle 2; `LoadValid`=0.
- SB at addr 0x101, `WriteData`=0x000000A5 -> `MemAddr`=0x100, `MemBe`=0010, `MemWData`=0xA5A5A5A5.
- LB at addr 0x203, `MemRData`=0x80112233 -> `MemAddr`=0x200, `MemBe`=1000; DONE gives `ReadData`=0xFFFFFF80 and `LoadValid`=1 for exactly one cycle.
- LHU at addr 0x202, `MemRData`=0xBEEF1234, `MemReady` delayed 3 cycles -> bus signals stable throughout ACCESS, `Stall` high for 5 cycles, then `ReadData`=0x0000BEEF.
- LW at addr 0x102, then `Funct3`=011 at addr 0x0 -> each gives a `MisalignedErr` pulse in cycle 1, `MemReq` stays 0, `ReadData` unchanged.
- `rst_n` low during ACCESS of LW 0x300 -> `MemReq`/`Stall` drop without a clock edge, no `LoadValid`. After release, a fresh LW 0x300 completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: turns an ALU effective address into one
// data-memory transaction, stalls the pipeline meanwhile, and returns extended load data.
module load_store_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    output logic                  Stall,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  LoadValid,
    output logic                  MisalignedErr,
    output logic                  MemReq,
    output logic                  MemWe,
    output logic [DATA_WIDTH-1:0] MemAddr,
    output logic [DATA_WIDTH-1:0] MemWData,
    output logic [3:0]            MemBe,
    input  logic                  MemReady,
    input  logic [DATA_WIDTH-1:0] MemRData,
    output logic [1:0]            state_dbg
);

    // Bus handshake: MemReq stays high with MemAddr/MemWe/MemBe/MemWData frozen
    // until a rising edge samples MemReady=1; that edge completes the transfer.
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    state_t                  state_q, state_d;
    logic                    req;
    logic                    bad;
    logic [3:0]              be_d;
    logic [DATA_WIDTH-1:0]   wdata_d;
    logic [1:0]              off_q;
    logic [2:0]              f3_q;
    logic                    load_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   lane;
    logic [DATA_WIDTH-1:0]   ext;

    assign req       = MemRead | MemWrite;
    assign state_dbg = state_q;

    always_comb begin
        bad     = 1'b0;
        be_d    = 4'b0000;
        wdata_d = '0;
        case (Funct3)
            3'b000, 3'b100: begin
                be_d    = 4'b0001 << ALUResult[1:0];
                wdata_d = {4{WriteData[7:0]}};
            end
            3'b001, 3'b101: begin
                bad     = ALUResult[0];
                be_d    = 4'b0011 << ALUResult[1:0];
                wdata_d = {2{WriteData[15:0]}};
            end
            3'b010: begin
                bad     = (ALUResult[1:0] != 2'b00);
                be_d    = 4'b1111;
                wdata_d = WriteData;
            end
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        lane = MemRData >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ext = {24'd0, lane[7:0]};
            3'b101:  ext = {16'd0, lane[15:0]};
            default: ext = lane;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = bad ? DONE : ACCESS;
            ACCESS:  if (MemReady) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stall is gated by reset so an abandoned request cannot hold the pipeline.
    always_comb begin
        Stall         = rst_n && ((state_q == IDLE && req) || state_q == ACCESS);
        MemReq        = (state_q == ACCESS);
        LoadValid     = (state_q == DONE) && load_q && !err_q;
        MisalignedErr = (state_q == DONE) && err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MemAddr  <= '0;
            MemWData <= '0;
            MemBe    <= 4'b0000;
            MemWe    <= 1'b0;
            off_q    <= 2'b00;
            f3_q     <= 3'b000;
            load_q   <= 1'b0;
            err_q    <= 1'b0;
            ReadData <= '0;
        end else begin
            if (state_q == IDLE && req) begin
                if (bad) begin
                    err_q  <= 1'b1;
                    load_q <= 1'b0;
                end else begin
                    err_q    <= 1'b0;
                    load_q   <= !MemWrite;
                    MemWe    <= MemWrite;
                    MemAddr  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
                    off_q    <= ALUResult[1:0];
                    f3_q     <= Funct3;
                    MemBe    <= be_d;
                    MemWData <= wdata_d;
                end
            end
            if (state_q == ACCESS && MemReady && load_q)
                ReadData <= ext;
        end
    end

endmodule
